// File: rtl/segasys1_pkg.sv
// Shared definitions for the System 1 sound-command path: FSM state type, default NMI timing
// constants and the counter-width helper.
package segasys1_pkg;

    localparam int unsigned NMI_TMO_DEF = 4096;
    localparam int unsigned NMI_GAP_DEF = 16;
    localparam int unsigned QLOG2_DEF   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StNmiOn = 2'd1,
        StGap   = 2'd2
    } sndcmd_state_e;

    function automatic int unsigned cnt_width(input int unsigned tmo, input int unsigned gap);
        int unsigned m;
        m = (tmo > gap) ? tmo : gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/segasys1_sndcmd_fifo.sv
// Synchronous FIFO holding main-CPU sound commands queued behind the latch.
// Data is first-word fall-through; a push while full is accepted only alongside a pop.
module segasys1_sndcmd_fifo
    import segasys1_pkg::*;
#(
    parameter int unsigned QLOG2 = QLOG2_DEF,
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK48M,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** QLOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [QLOG2:0]   wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[QLOG2] != rd_ptr_q[QLOG2]) &&
                     (wr_ptr_q[QLOG2-1:0] == rd_ptr_q[QLOG2-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_q[QLOG2-1:0]];

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK48M) begin
        if (do_push) mem[wr_ptr_q[QLOG2-1:0]] <= din;
    end

endmodule

// File: rtl/segasys1_sndcmd_ctrl.sv
// Main-to-sound CPU command latch with retriggering NMI sequencer.
// Define SEGASYS1_SNDQ_EN to place a 2**QLOG2-entry FIFO in front of the latch.
module segasys1_sndcmd_ctrl
    import segasys1_pkg::*;
#(
    parameter int unsigned NMI_TMO = NMI_TMO_DEF,
    parameter int unsigned NMI_GAP = NMI_GAP_DEF
`ifdef SEGASYS1_SNDQ_EN
    ,
    parameter int unsigned QLOG2 = QLOG2_DEF
`endif
) (
    input  logic       CLK48M,
    input  logic       RESET,
    input  logic       MCMD_WR,
    input  logic [7:0] MCMD_DT,
    input  logic       SCMD_RD,
    output logic [7:0] SCMD_DT,
    output logic       SNMI,
    output logic       SPEND,
    output logic       MBUSY,
    output logic       OVF,
    input  logic       OVF_CLR
);

    localparam int unsigned  CW       = cnt_width(NMI_TMO, NMI_GAP);
    localparam logic [CW-1:0] TMO_LAST = CW'(NMI_TMO - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(NMI_GAP - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    sndcmd_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    dt_q, dt_d;
    logic          spend_q, spend_d;
    logic          snmi_q, snmi_d;
    logic          ovf_q, ovf_d;
    logic          wr_q, rd_q;

    logic          wr_edge, rd_edge, rd_take, load, ovf_evt, gap_end;

`ifdef SEGASYS1_SNDQ_EN
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;

    segasys1_sndcmd_fifo #(
        .QLOG2 (QLOG2),
        .WIDTH (8)
    ) u_fifo (
        .CLK48M (CLK48M),
        .RESET  (RESET),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (MCMD_DT),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign MBUSY = fifo_full;
`else
    assign MBUSY = spend_q;
`endif

    assign wr_edge = MCMD_WR & ~wr_q;
    assign rd_edge = SCMD_RD & ~rd_q;
    // A read only counts when there is something in the latch to consume.
    assign rd_take = rd_edge & spend_q;
    assign gap_end = (state_q == StGap) && (cnt_q == GAP_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        dt_d    = dt_q;
        spend_d = spend_q;
        snmi_d  = snmi_q;
        ovf_d   = ovf_q;

`ifdef SEGASYS1_SNDQ_EN
        // Bypass the queue only when nothing older is waiting anywhere.
        load      = wr_edge & (~spend_q | rd_take) & fifo_empty;
        fifo_push = wr_edge & ~load;
        fifo_pop  = gap_end & ~((spend_q & ~rd_take) | load) & ~fifo_empty;
        ovf_evt   = fifo_push & fifo_full & ~fifo_pop;
`else
        load      = wr_edge & (~spend_q | rd_take);
        ovf_evt   = wr_edge & ~load;
`endif

        if (rd_take) spend_d = 1'b0;
        if (load) begin
            dt_d    = MCMD_DT;
            spend_d = 1'b1;
        end
`ifdef SEGASYS1_SNDQ_EN
        if (fifo_pop) begin
            dt_d    = fifo_dout;
            spend_d = 1'b1;
        end
`else
        if (ovf_evt) dt_d = MCMD_DT;
`endif

        if (OVF_CLR)      ovf_d = 1'b0;
        else if (ovf_evt) ovf_d = 1'b1;

        case (state_q)
            StIdle: begin
                if (load) begin
                    snmi_d  = 1'b1;
                    state_d = StNmiOn;
                    cnt_d   = '0;
                end
            end
            StNmiOn: begin
                if (rd_take || (cnt_q == TMO_LAST)) begin
                    snmi_d  = 1'b0;
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                // Read-and-replace during the gap restarts it so the new byte gets a full gap.
                if (rd_take && load) begin
                    cnt_d = '0;
                end else if (gap_end) begin
                    cnt_d = '0;
                    if (spend_d) begin
                        snmi_d  = 1'b1;
                        state_d = StNmiOn;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                snmi_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dt_q    <= '0;
            spend_q <= 1'b0;
            snmi_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dt_q    <= dt_d;
            spend_q <= spend_d;
            snmi_q  <= snmi_d;
            ovf_q   <= ovf_d;
            wr_q    <= MCMD_WR;
            rd_q    <= SCMD_RD;
        end
    end

    assign SCMD_DT = dt_q;
    assign SNMI    = snmi_q;
    assign SPEND   = spend_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_segasys1_sndcmd_ctrl.sv
// Self-checking bench for segasys1_sndcmd_ctrl: directed scenarios plus a randomized run
// compared against an event-level reference model of the command handshake.
module tb_segasys1_sndcmd_ctrl;

    logic       CLK48M = 1'b0;
    logic       RESET = 1'b0;
    logic       MCMD_WR = 1'b0;
    logic [7:0] MCMD_DT = 8'h00;
    logic       SCMD_RD = 1'b0;
    logic       OVF_CLR = 1'b0;
    logic [7:0] SCMD_DT;
    logic       SNMI, SPEND, MBUSY, OVF;

    int total = 0;
    int bad = 0;

    // Reference model: pending byte, NMI on/off and time spent in the current NMI phase.
    bit         m_wr_prev, m_rd_prev, m_pend, m_ovf, m_nmi, m_active;
    logic [7:0] m_byte;
    int         m_elapsed;

    segasys1_sndcmd_ctrl dut (
        .CLK48M  (CLK48M),
        .RESET   (RESET),
        .MCMD_WR (MCMD_WR),
        .MCMD_DT (MCMD_DT),
        .SCMD_RD (SCMD_RD),
        .SCMD_DT (SCMD_DT),
        .SNMI    (SNMI),
        .SPEND   (SPEND),
        .MBUSY   (MBUSY),
        .OVF     (OVF),
        .OVF_CLR (OVF_CLR)
    );

    always #5 CLK48M = ~CLK48M;

    task automatic model_reset();
        m_wr_prev = 0; m_rd_prev = 0; m_pend = 0; m_ovf = 0;
        m_nmi = 0; m_active = 0; m_byte = 8'h00; m_elapsed = 0;
    endtask

    task automatic model_step();
        bit wr_e, rd_e, consumed, new_pend;
        wr_e = MCMD_WR && !m_wr_prev;
        rd_e = SCMD_RD && !m_rd_prev;
        m_wr_prev = MCMD_WR;
        m_rd_prev = SCMD_RD;
        consumed = rd_e && m_pend;
        if (OVF_CLR) m_ovf = 0;
        else if (wr_e && m_pend && !consumed) m_ovf = 1;
        if (wr_e) m_byte = MCMD_DT;
        new_pend = (m_pend && !consumed) || wr_e;
        if (!m_active) begin
            if (wr_e) begin m_active = 1; m_nmi = 1; m_elapsed = 0; end
        end else if (m_nmi) begin
            if (consumed || m_elapsed == 4095) begin m_nmi = 0; m_elapsed = 0; end
            else m_elapsed++;
        end else begin
            if (consumed && wr_e) m_elapsed = 0;
            else if (m_elapsed == 15) begin
                m_elapsed = 0;
                if (new_pend) m_nmi = 1;
                else m_active = 0;
            end else m_elapsed++;
        end
        m_pend = new_pend;
    endtask

    task automatic step();
        model_step();
        @(posedge CLK48M);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        SCMD_RD = 1'b1; step(); SCMD_RD = 1'b0;
        step_n(20);
    endtask

    task automatic test_reset();
        logic [11:0] got;
        #2 RESET = 1'b1;
        #1;
        got = {SCMD_DT, SNMI, SPEND, MBUSY, OVF};
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL por_outputs got=%h want=000", got); end
        repeat (3) @(posedge CLK48M);
        #1 RESET = 1'b0;
        model_reset();
        MCMD_DT = 8'h77; MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0;
        step_n(5);
        total++;
        if (SNMI !== 1'b1) begin bad++; $display("FAIL reset_pre_snmi got=%b want=1", SNMI); end
        RESET = 1'b1;
        #1;
        got = {SCMD_DT, SNMI, SPEND, MBUSY, OVF};
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL reset_async got=%h want=000", got); end
        repeat (2) @(posedge CLK48M);
        #1 RESET = 1'b0;
        model_reset();
        step();
        total++;
        if (SNMI !== 1'b0 || SPEND !== 1'b0) begin
            bad++; $display("FAIL reset_release snmi=%b spend=%b want=0/0", SNMI, SPEND);
        end
    endtask

    task automatic test_basic();
        MCMD_DT = 8'h5A; MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0;
        total++;
        if ({SNMI, SPEND, MBUSY} !== 3'b111 || SCMD_DT !== 8'h5A) begin
            bad++; $display("FAIL basic_load snmi/spend/mbusy=%b dt=%h want=111 5a",
                            {SNMI, SPEND, MBUSY}, SCMD_DT);
        end
        step();
        SCMD_RD = 1'b1; step(); SCMD_RD = 1'b0;
        total++;
        if (SNMI !== 1'b0 || SPEND !== 1'b0) begin
            bad++; $display("FAIL basic_read snmi=%b spend=%b want=0/0", SNMI, SPEND);
        end
        step_n(16);
        MCMD_DT = 8'hC3; MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0;
        total++;
        if (SNMI !== 1'b1 || SCMD_DT !== 8'hC3) begin
            bad++; $display("FAIL basic_idle_relatch snmi=%b dt=%h want=1 c3", SNMI, SCMD_DT);
        end
        drain();
    endtask

    task automatic test_timeout();
        int hi, lo, spend_bad, guard;
        hi = 0; lo = 0; spend_bad = 0; guard = 0;
        MCMD_DT = 8'hA7; MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0;
        while (SNMI === 1'b1 && guard < 5000) begin
            hi++; if (SPEND !== 1'b1) spend_bad++; step(); guard++;
        end
        while (SNMI === 1'b0 && guard < 5200) begin
            lo++; if (SPEND !== 1'b1) spend_bad++; step(); guard++;
        end
        total++;
        if (hi != 4096) begin bad++; $display("FAIL tmo_high got=%0d want=4096", hi); end
        total++;
        if (lo != 16) begin bad++; $display("FAIL tmo_gap got=%0d want=16", lo); end
        total++;
        if (SNMI !== 1'b1 || SCMD_DT !== 8'hA7) begin
            bad++; $display("FAIL tmo_retrigger snmi=%b dt=%h want=1 a7", SNMI, SCMD_DT);
        end
        total++;
        if (spend_bad != 0) begin bad++; $display("FAIL tmo_spend drops=%0d want=0", spend_bad); end
        drain();
    endtask

    task automatic test_overwrite();
        MCMD_DT = 8'h11; MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0; step();
        MCMD_DT = 8'h22; MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0;
        total++;
        if (SCMD_DT !== 8'h22 || OVF !== 1'b1 || SNMI !== 1'b1) begin
            bad++; $display("FAIL ovw_latch dt=%h ovf=%b snmi=%b want=22 1 1", SCMD_DT, OVF, SNMI);
        end
        OVF_CLR = 1'b1; step(); OVF_CLR = 1'b0;
        total++;
        if (OVF !== 1'b0) begin bad++; $display("FAIL ovw_clear ovf=%b want=0", OVF); end
        OVF_CLR = 1'b1; MCMD_DT = 8'h44; MCMD_WR = 1'b1; step();
        OVF_CLR = 1'b0; MCMD_WR = 1'b0;
        total++;
        if (OVF !== 1'b0 || SCMD_DT !== 8'h44) begin
            bad++; $display("FAIL ovw_clr_wins ovf=%b dt=%h want=0 44", OVF, SCMD_DT);
        end
        drain();
    endtask

    task automatic test_same_cycle();
        int lo;
        MCMD_DT = 8'h20; MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0; step();
        MCMD_DT = 8'h33; MCMD_WR = 1'b1; SCMD_RD = 1'b1; step();
        MCMD_WR = 1'b0; SCMD_RD = 1'b0;
        total++;
        if ({SNMI, SPEND, OVF} !== 3'b010) begin
            bad++; $display("FAIL same_cycle snmi/spend/ovf=%b want=010", {SNMI, SPEND, OVF});
        end
        lo = 0;
        while (SNMI === 1'b0 && lo < 100) begin lo++; step(); end
        total++;
        if (lo != 16) begin bad++; $display("FAIL same_cycle_gap got=%0d want=16", lo); end
        total++;
        if (SNMI !== 1'b1 || SCMD_DT !== 8'h33) begin
            bad++; $display("FAIL same_cycle_renmi snmi=%b dt=%h want=1 33", SNMI, SCMD_DT);
        end
        drain();
    endtask

    task automatic test_read_idle();
        logic [7:0] want;
        want = m_byte;
        SCMD_RD = 1'b1; step(); SCMD_RD = 1'b0; step();
        total++;
        if (SPEND !== 1'b0 || SNMI !== 1'b0 || SCMD_DT !== want) begin
            bad++; $display("FAIL read_idle spend=%b snmi=%b dt=%h want=0 0 %h",
                            SPEND, SNMI, SCMD_DT, want);
        end
    endtask

`ifndef SEGASYS1_SNDQ_EN
    task automatic test_random();
        logic [11:0] got, exp;
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            MCMD_WR = ($urandom_range(0, 9) == 0);
            SCMD_RD = ($urandom_range(0, 7) == 0);
            OVF_CLR = ($urandom_range(0, 31) == 0);
            MCMD_DT = 8'($urandom);
            step();
            got = {SCMD_DT, SNMI, SPEND, MBUSY, OVF};
            exp = {m_byte, m_nmi, m_pend, m_pend, m_ovf};
            total++;
            if (got !== exp) begin
                bad++; errs++;
                if (errs <= 20) $display("FAIL random_cycle%0d got=%h want=%h", i, got, exp);
            end
        end
        MCMD_WR = 1'b0; SCMD_RD = 1'b0; OVF_CLR = 1'b0;
        step_n(2);
    endtask
`else
    task automatic test_queue();
        int guard;
        OVF_CLR = 1'b1; step(); OVF_CLR = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            MCMD_DT = 8'(i); MCMD_WR = 1'b1; step(); MCMD_WR = 1'b0; step();
        end
        total++;
        if (SCMD_DT !== 8'h01 || OVF !== 1'b1 || MBUSY !== 1'b1) begin
            bad++; $display("FAIL queue_fill dt=%h ovf=%b mbusy=%b want=01 1 1", SCMD_DT, OVF, MBUSY);
        end
        for (int i = 1; i <= 5; i++) begin
            guard = 0;
            while (SNMI !== 1'b1 && guard < 100) begin step(); guard++; end
            total++;
            if (SNMI !== 1'b1 || SCMD_DT !== 8'(i)) begin
                bad++; $display("FAIL queue_read%0d snmi=%b dt=%h want=1 %h", i, SNMI, SCMD_DT, 8'(i));
            end
            SCMD_RD = 1'b1; step(); SCMD_RD = 1'b0; step();
        end
        step_n(20);
        SCMD_RD = 1'b1; step(); SCMD_RD = 1'b0; step_n(20);
        total++;
        if (SNMI !== 1'b0 || SPEND !== 1'b0 || SCMD_DT !== 8'h05) begin
            bad++; $display("FAIL queue_sixth snmi=%b spend=%b dt=%h want=0 0 05", SNMI, SPEND, SCMD_DT);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_timeout();
`ifndef SEGASYS1_SNDQ_EN
        test_overwrite();
`endif
        test_same_cycle();
        test_read_idle();
`ifndef SEGASYS1_SNDQ_EN
        test_random();
`else
        test_queue();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
